// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default parameters for the SPI master.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t;
    localparam int SPI_DATA_WIDTH = 8;
    localparam int SPI_CLK_DIV = 1;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides clk into sclk and flags the edges on which sclk toggles.
// Ports: clk, rst (async active-low), en (count), clr (restart at sclk low),
//        sclk (idle low), rise/fall (high in the cycle whose closing edge toggles sclk).
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    logic [DW-1:0] div_q, div_d;
    logic sclk_q, sclk_d, tc;
    always_comb begin
        tc = en && (div_q == DW'(CLK_DIV - 1));
        rise = tc && !sclk_q;
        fall = tc && sclk_q;
        div_d = clr ? '0 : !en ? div_q : tc ? '0 : div_q + 1'b1;
        sclk_d = clr ? 1'b0 : tc ? ~sclk_q : sclk_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sclk_q <= sclk_d;
        end
    end
    assign sclk = sclk_q;
endmodule

// File: rtl/spi_master.sv
// spi_master: free-running transmit-only SPI mode-0 master, MSB first.
// Ports: clk, rst (async active-low), d_in (word captured at frame start),
//        ss (active-low select), mosi (serial data), sclk (idle low), done (end-of-frame pulse).
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic                  ss,
    output logic                  mosi,
    output logic                  sclk,
    output logic                  done
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    spi_state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ss_q, ss_d, mosi_q, mosi_d, done_q, done_d;
    logic fall, rise_unused;
    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk (clk),
        .rst (rst),
        .en  (state_q == SHIFT),
        .clr (state_q == IDLE),
        .sclk(sclk),
        .rise(rise_unused),
        .fall(fall)
    );
    // mosi only moves on the falling sclk edge, so the slave sees it settled at every rise
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d = cnt_q;
        ss_d = ss_q;
        mosi_d = mosi_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                shift_d = d_in;
                mosi_d = d_in[DATA_WIDTH-1];
                ss_d = 1'b0;
                cnt_d = CW'(DATA_WIDTH - 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                if (fall && cnt_q != '0) begin
                    shift_d = shift_q << 1;
                    cnt_d = cnt_q - 1'b1;
                    mosi_d = shift_d[DATA_WIDTH-1];
                end else if (fall) begin
                    ss_d = 1'b1;
                    mosi_d = 1'b0;
                    done_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q <= '0;
            ss_q <= 1'b1;
            mosi_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q <= cnt_d;
            ss_q <= ss_d;
            mosi_q <= mosi_d;
            done_q <= done_d;
        end
    end
    assign ss = ss_q;
    assign mosi = mosi_q;
    assign done = done_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master at CLK_DIV=1 and CLK_DIV=4.
module tb_spi_master;
    logic clk = 1'b0;
    logic [1:0] rst_v = 2'b00;
    logic [7:0] d_v [2];
    logic [1:0] ss_v, mosi_v, sclk_v, done_v;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc [2];
    int next_done [2];
    int ss_lo [2];
    int hi [2];
    int lo [2];
    int nb [2];
    logic [7:0] bits [2];
    logic [1:0] prev_sclk;

    always #5 clk = ~clk;

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst_v[0]), .d_in(d_v[0]),
        .ss(ss_v[0]), .mosi(mosi_v[0]), .sclk(sclk_v[0]), .done(done_v[0])
    );
    spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst_v[1]), .d_in(d_v[1]),
        .ss(ss_v[1]), .mosi(mosi_v[1]), .sclk(sclk_v[1]), .done(done_v[1])
    );

    function automatic int div_of(int i);
        return i == 0 ? 1 : 4;
    endfunction

    task automatic check(string tag, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(int i, logic [7:0] v);
        d_v[i] = v;
        if (i == 0) exp0.push_back(v);
        else exp1.push_back(v);
    endtask

    task automatic wait_done(int i);
        bit seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(posedge clk);
            #2;
            seen = done_v[i];
        end
        if (!seen) check($sformatf("timeout_dut%0d", i), 0, 1);
    endtask

    task automatic check_idle_outputs(string tag, int i);
        check($sformatf("%s_ss_dut%0d", tag, i), int'(ss_v[i]), 1);
        check($sformatf("%s_mosi_dut%0d", tag, i), int'(mosi_v[i]), 0);
        check($sformatf("%s_sclk_dut%0d", tag, i), int'(sclk_v[i]), 0);
        check($sformatf("%s_done_dut%0d", tag, i), int'(done_v[i]), 0);
    endtask

    task automatic run(int i);
        @(posedge clk);
        #2;
        push(i, 8'hA5);
        rst_v[i] = 1'b1;
        wait_done(i);
        push(i, 8'h3C);
        wait_done(i);
        push(i, 8'hFF);
        wait_done(i);
        push(i, 8'h81);
        repeat (7) @(posedge clk);
        #2;
        push(i, 8'h00);
        wait_done(i);
        wait_done(i);
        push(i, 8'h5A);
        wait_done(i);
        push(i, 8'hC3);
        repeat (9) @(posedge clk);
        #3;
        rst_v[i] = 1'b0;
        #1;
        check_idle_outputs("abort", i);
        if (i == 0) exp0.delete();
        else exp1.delete();
        repeat (3) @(posedge clk);
        #2;
        push(i, 8'h96);
        rst_v[i] = 1'b1;
        wait_done(i);
        repeat (2) @(posedge clk);
        #2;
        rst_v[i] = 1'b0;
        check($sformatf("leftover_dut%0d", i), i == 0 ? exp0.size() : exp1.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) cyc[i] = rst_v[i] ? cyc[i] + 1 : 0;
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_v[i]) begin
                bits[i] = '0;
                nb[i] = 0;
                ss_lo[i] = 0;
                hi[i] = 0;
                lo[i] = 0;
                prev_sclk[i] = 1'b0;
                next_done[i] = 16 * div_of(i) + 1;
            end else begin
                if (!ss_v[i]) ss_lo[i]++;
                if (sclk_v[i] && !prev_sclk[i]) begin
                    bits[i] = {bits[i][6:0], mosi_v[i]};
                    nb[i]++;
                    check($sformatf("sclk_low_len_dut%0d", i), lo[i], div_of(i));
                    lo[i] = 0;
                end
                if (!sclk_v[i] && prev_sclk[i]) begin
                    check($sformatf("sclk_high_len_dut%0d", i), hi[i], div_of(i));
                    hi[i] = 0;
                end
                if (sclk_v[i]) hi[i]++;
                else if (!ss_v[i]) lo[i]++;
                prev_sclk[i] = sclk_v[i];
                if (done_v[i]) begin
                    check($sformatf("ss_at_done_dut%0d", i), int'(ss_v[i]), 1);
                    check($sformatf("ss_low_len_dut%0d", i), ss_lo[i], 16 * div_of(i));
                    check($sformatf("bits_dut%0d", i), nb[i], 8);
                    check($sformatf("done_cycle_dut%0d", i), cyc[i], next_done[i]);
                    if ((i == 0 ? exp0.size() : exp1.size()) == 0)
                        check($sformatf("spurious_done_dut%0d", i), 1, 0);
                    else
                        check($sformatf("data_dut%0d", i), int'(bits[i]),
                              int'(i == 0 ? exp0.pop_front() : exp1.pop_front()));
                    next_done[i] += 16 * div_of(i) + 2;
                    ss_lo[i] = 0;
                    nb[i] = 0;
                end
            end
        end
    end

    initial begin
        d_v[0] = '0;
        d_v[1] = '0;
        repeat (2) @(posedge clk);
        #2;
        check_idle_outputs("reset", 0);
        check_idle_outputs("reset", 1);
        run(0);
        run(1);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
